// File: rtl/irq_sequencer_pkg.sv
// irq_seq_pkg
//   Shared types and constants for the exception entry/exit sequencer:
//   sequencer state encoding, the EXC_RETURN magic value, the layout of
//   the 8-word exception frame and the mapping from frame slot to
//   register-file index.
package irq_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_PUSH,
        ST_VECTOR,
        ST_ENTER,
        ST_HANDLER,
        ST_POP,
        ST_RETURN
    } seq_state_e;

    // Value the core loads into LR on exception entry (lr_load).
    localparam logic [31:0] EXC_RETURN = 32'hFFFF_FFF9;

    // Frame slots, in ascending address order from the frame base.
    localparam logic [2:0] SLOT_R0   = 3'd0;
    localparam logic [2:0] SLOT_R1   = 3'd1;
    localparam logic [2:0] SLOT_R2   = 3'd2;
    localparam logic [2:0] SLOT_R3   = 3'd3;
    localparam logic [2:0] SLOT_R12  = 3'd4;
    localparam logic [2:0] SLOT_LR   = 3'd5;
    localparam logic [2:0] SLOT_PC   = 3'd6;
    localparam logic [2:0] SLOT_XPSR = 3'd7;

    localparam int unsigned FRAME_BYTES = 32;

    // Register-file index held in a frame slot. Only meaningful for
    // SLOT_R0..SLOT_LR; PC and xPSR are not register-file entries.
    function automatic logic [3:0] slot_reg(input logic [2:0] slot);
        case (slot)
            SLOT_R12: slot_reg = 4'd12;
            SLOT_LR:  slot_reg = 4'd14;
            default:  slot_reg = {1'b0, slot};
        endcase
    endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// irq_sequencer_if
//   Shared data-memory port used to stack and unstack the exception frame
//   and to fetch handler vectors.
//   mem_req   request valid, held with stable addr/we/wdata until mem_ack
//   mem_we    write strobe
//   mem_addr  byte address
//   mem_wdata write data
//   mem_rdata read data, valid in the cycle mem_ack is high
//   mem_ack   transfer completes in the cycle it is sampled high
interface irq_sequencer_if
    import irq_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/irq_sequencer_priority_enc.sv
// irq_priority_enc
//   Combinational fixed-priority encoder; the lowest set index wins.
//   req_i    request vector
//   valid_o  any request set
//   idx_o    index of the winning request (0 when none)
module irq_priority_enc
    import irq_seq_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [3:0]         idx_o
);

    // Scan from the top down so the lowest set index is assigned last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (req_i[i-1]) begin
                valid_o = 1'b1;
                idx_o   = 4'(i - 1);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer
//   Single-level exception entry/exit sequencer. Arbitrates enabled
//   interrupt lines (lowest index first), freezes the pipeline, stacks the
//   8-word frame R0,R1,R2,R3,R12,LR,PC,xPSR below the current SP, fetches
//   the handler vector and redirects PC/SP/LR. On exception return it
//   unstacks the frame, restores registers, PC, xPSR and SP, then releases
//   the pipeline.
//   clk, rst                 clock, synchronous active-high reset
//   irq_req, irq_en          level requests and per-line enables
//   pipe_idle / pipe_hold    pipeline drained / freeze fetch+decode
//   exc_return               handler returned (one-cycle pulse)
//   cur_pc, cur_sp, cur_xpsr core state to stack
//   reg_rd_*, reg_wr_*       register-file read (combinational) and write
//   mem                      data-memory port (master side)
//   pc_*, sp_*, lr_load, xpsr_*  core state update pulses
//   in_handler, active_irq   handler active, serviced index
module irq_sequencer
    import irq_seq_pkg::*;
#(
    parameter int unsigned       NUM_IRQ  = 8,
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE = 16'h0040
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_req,
    input  logic [NUM_IRQ-1:0]  irq_en,
    input  logic                pipe_idle,
    output logic                pipe_hold,
    input  logic                exc_return,
    input  logic [ADDR_W-1:0]   cur_pc,
    input  logic [ADDR_W-1:0]   cur_sp,
    input  logic [31:0]         cur_xpsr,
    output logic [3:0]          reg_rd_addr,
    input  logic [31:0]         reg_rd_data,
    output logic                reg_wr_en,
    output logic [3:0]          reg_wr_addr,
    output logic [31:0]         reg_wr_data,
    irq_sequencer_if.master     mem,
    output logic                pc_load,
    output logic [ADDR_W-1:0]   pc_value,
    output logic                sp_load,
    output logic [ADDR_W-1:0]   sp_value,
    output logic                lr_load,
    output logic                xpsr_load,
    output logic [31:0]         xpsr_value,
    output logic                in_handler,
    output logic [3:0]          active_irq
);

    seq_state_e        state_q, state_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [2:0]        k_q, k_d;
    logic [ADDR_W-1:0] fb_q, fb_d;
    logic [3:0]        active_q, active_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       xpsr_q, xpsr_d;

    logic              win_valid;
    logic [3:0]        win_idx;
    logic [NUM_IRQ-1:0] pend_clr;

    irq_priority_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req_i   (pend_q),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            k_q      <= '0;
            fb_q     <= '0;
            active_q <= '0;
            pc_q     <= '0;
            xpsr_q   <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            k_q      <= k_d;
            fb_q     <= fb_d;
            active_q <= active_d;
            pc_q     <= pc_d;
            xpsr_q   <= xpsr_d;
        end
    end

    // Pending bits: the ENTER clear wins over a same-cycle request, so a
    // level still held re-pends one cycle later.
    always_comb begin
        pend_clr = '0;
        if (state_q == ST_ENTER) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                pend_clr[i] = (active_q == 4'(i));
            end
        end
        pend_d = (pend_q | (irq_req & irq_en)) & ~pend_clr;
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        fb_d        = fb_q;
        active_d    = active_q;
        pc_d        = pc_q;
        xpsr_d      = xpsr_q;

        pipe_hold   = 1'b0;
        reg_rd_addr = '0;
        reg_wr_en   = 1'b0;
        reg_wr_addr = '0;
        reg_wr_data = '0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        pc_load     = 1'b0;
        pc_value    = '0;
        sp_load     = 1'b0;
        sp_value    = '0;
        lr_load     = 1'b0;
        xpsr_load   = 1'b0;
        xpsr_value  = '0;
        in_handler  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    active_d = win_idx;
                    state_d  = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                pipe_hold = 1'b1;
                if (pipe_idle) begin
                    fb_d    = cur_sp - ADDR_W'(FRAME_BYTES);
                    k_d     = '0;
                    state_d = ST_PUSH;
                end
            end

            ST_PUSH: begin
                pipe_hold     = 1'b1;
                reg_rd_addr   = slot_reg(k_q);
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = fb_q + ADDR_W'({k_q, 2'b00});
                case (k_q)
                    SLOT_PC:   mem.mem_wdata = 32'(cur_pc);
                    SLOT_XPSR: mem.mem_wdata = cur_xpsr;
                    default:   mem.mem_wdata = reg_rd_data;
                endcase
                if (mem.mem_ack) begin
                    k_d = k_q + 3'd1;
                    if (k_q == SLOT_XPSR) begin
                        state_d = ST_VECTOR;
                    end
                end
            end

            ST_VECTOR: begin
                pipe_hold    = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_addr = VEC_BASE + ADDR_W'({active_q, 2'b00});
                if (mem.mem_ack) begin
                    pc_d    = {mem.mem_rdata[ADDR_W-1:1], 1'b0};
                    state_d = ST_ENTER;
                end
            end

            ST_ENTER: begin
                pipe_hold = 1'b1;
                pc_load   = 1'b1;
                pc_value  = pc_q;
                sp_load   = 1'b1;
                sp_value  = fb_q;
                lr_load   = 1'b1;
                state_d   = ST_HANDLER;
            end

            ST_HANDLER: begin
                in_handler = 1'b1;
                if (exc_return) begin
                    fb_d    = cur_sp;
                    k_d     = '0;
                    state_d = ST_POP;
                end
            end

            ST_POP: begin
                pipe_hold    = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_addr = fb_q + ADDR_W'({k_q, 2'b00});
                if (mem.mem_ack) begin
                    k_d = k_q + 3'd1;
                    case (k_q)
                        SLOT_PC:   pc_d = mem.mem_rdata[ADDR_W-1:0];
                        SLOT_XPSR: begin
                            xpsr_d  = mem.mem_rdata;
                            state_d = ST_RETURN;
                        end
                        default: begin
                            reg_wr_en   = 1'b1;
                            reg_wr_addr = slot_reg(k_q);
                            reg_wr_data = mem.mem_rdata;
                        end
                    endcase
                end
            end

            ST_RETURN: begin
                pipe_hold  = 1'b1;
                pc_load    = 1'b1;
                pc_value   = pc_q;
                xpsr_load  = 1'b1;
                xpsr_value = xpsr_q;
                sp_load    = 1'b1;
                sp_value   = fb_q + ADDR_W'(FRAME_BYTES);
                state_d    = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign active_irq = active_q;

endmodule
